mem_readout: RTL and testbench
==============================

Name: mem_readout

Overview:
- Readout engine for the capture memory: the read side of the sample buffer that the capture logic fills.
- On a start command it reads a block of stored sample words and splits each word into bytes, most significant byte first.
- Bytes go out on a valid/ready byte stream toward the host link transmitter (UART TX).
- Drives the memory address and write-enable; consumes the memory's registered read data, which has 1-cycle latency.

Parameters:
- width, 11, memory address width; depth = 1<<width words.
- mem_size, 32, memory word width in bits; must be a multiple of 8; BYTES = mem_size/8.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; ignored unless idle.
- abort  in  1  synchronous abort; returns to idle without done.
- base_adr  in  width  first word address, sampled on accepted start.
- count  in  width+1  number of words to read, sampled on accepted start; range 0..depth.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- mem_adr  out  width  registered memory address.
- mem_we  out  1  memory write enable; constant 0 from this block.
- mem_dat_i  in  mem_size  memory read data, valid the cycle after mem_adr is presented.
- tx_data  out  8  stream byte.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  downstream accepts when tx_valid&&tx_ready.

Behaviour:
- Reset values: busy=0, done=0, mem_adr=0, mem_we=0, tx_valid=0, tx_data=0, state=IDLE; all counters and the shift register cleared.
- A reset mid-transfer drops tx_valid immediately (async) and discards all progress.
- IDLE:
  - start=1: latch base_adr into cur_adr, latch count into remaining.
  - count==0: go to FIN.
  - Otherwise go to ADDR.
- ADDR (1 cycle):
  - mem_adr=cur_adr.
  - Memory samples the address at the end of this cycle.
  - Go to LOAD.
- LOAD (1 cycle):
  - mem_dat_i is valid; capture it into the shift register; byte_idx=0.
  - cur_adr = cur_adr+1 modulo depth (wraps from depth-1 to 0).
  - remaining -= 1.
  - Go to SEND.
- SEND:
  - tx_valid=1; tx_data = shift register bits [mem_size-1 -: 8].
  - On handshake: shift left by 8, byte_idx+1.
  - After the handshake of byte BYTES-1: go to ADDR if remaining!=0, otherwise go to TAIL (feature enabled) or FIN.
  - tx_valid and tx_data stay stable while tx_ready=0.
- FIN (1 cycle):
  - done=1, then go to IDLE.
  - busy is high in FIN and low in IDLE.
- Throughput: BYTES+2 cycles per word minimum, with tx_ready held high.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; tx_valid falls the next cycle; done is not pulsed.
  - This is the only case where tx_valid drops without a handshake.
  - abort has priority over a handshake in the same cycle; that byte counts as not sent.
- start while busy is ignored. start and abort together in IDLE: abort wins, stays IDLE.
- count==depth reads every word once, starting at base_adr and wrapping.
- mem_we is never asserted; the write side owns the memory only when busy=0, and that arbitration sits outside this block.

Optional Feature:
- Macro MEM_READOUT_CSUM_EN.
- Defined:
  - Running 8-bit XOR of every byte handshaken in the current transfer; cleared on accepted start.
  - After the last data byte, state TAIL presents tx_data=checksum with tx_valid=1 until handshake, then goes to FIN.
  - count==0 still emits TAIL with checksum 0x00.
- Not defined: no TAIL state, no checksum logic; the last data byte goes straight to FIN.

Test Plan:
- Reset, memory preloaded with adr 5=0x11223344, start base_adr=5 count=1, tx_ready=1 -> mem_adr=5, bytes 0x11,0x22,0x33,0x44, then done pulse; busy high for exactly 7 cycles; CSUM build adds 0x44 (0x11^0x22^0x33^0x44).
- Backpressure: same word, tx_ready toggles 1,0,0,1,... -> each byte held stable while ready=0; output order unchanged; no duplicated byte.
- Wrap: width=11, base_adr=2047 count=3 -> addresses 2047,0,1 read in order; 12 bytes out.
- count=0 -> no tx_valid, done pulses 2 cycles after start; CSUM build emits single 0x00 first.
- abort asserted during the 2nd byte of word 2 of count=4 -> tx_valid low next cycle, no done, busy low; a following start runs a fresh transfer correctly.
- start pulses while busy, and rst_n dropped mid-SEND -> extra starts ignored; on reset tx_valid=0 and busy=0 asynchronously; a new start after reset works.

Source files
------------

// File: rtl/mem_readout.sv
// Capture-memory readout: reads a block of words and streams them out as bytes, MSB first.
// Optional trailing XOR checksum byte is enabled by defining MEM_READOUT_CSUM_EN.
module mem_readout #(
  parameter int width    = 11,
  parameter int mem_size = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [width-1:0]    base_adr,
  input  logic [width:0]      count,
  output logic                busy,
  output logic                done,
  output logic [width-1:0]    mem_adr,
  output logic                mem_we,
  input  logic [mem_size-1:0] mem_dat_i,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

  localparam int BYTES = mem_size / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
`ifdef MEM_READOUT_CSUM_EN
    TAIL = 3'd5,
`endif
    FIN  = 3'd4
  } state_t;

  state_t              state_reg;
  logic [width-1:0]    cur_adr_reg;
  logic [width:0]      remaining_reg;
  logic [mem_size-1:0] shift_reg;
  logic [mem_size-1:0] shift_next;
  logic [IDXW-1:0]     byte_idx_reg;
  logic                hs;
`ifdef MEM_READOUT_CSUM_EN
  logic [7:0]          csum_reg;
`endif

  assign mem_we     = 1'b0;
  assign hs         = tx_valid && tx_ready;
  assign shift_next = shift_reg << 8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_adr       <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      cur_adr_reg   <= '0;
      remaining_reg <= '0;
      shift_reg     <= '0;
      byte_idx_reg  <= '0;
`ifdef MEM_READOUT_CSUM_EN
      csum_reg      <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      // abort beats everything outside IDLE, including a same-cycle handshake
      if (abort && state_reg != IDLE) begin
        state_reg <= IDLE;
        busy      <= 1'b0;
        tx_valid  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !abort) begin
              cur_adr_reg   <= base_adr;
              remaining_reg <= count;
              mem_adr       <= base_adr;
              busy          <= 1'b1;
`ifdef MEM_READOUT_CSUM_EN
              csum_reg      <= 8'h00;
`endif
              if (count == '0) begin
`ifdef MEM_READOUT_CSUM_EN
                state_reg <= TAIL;
                tx_valid  <= 1'b1;
                tx_data   <= 8'h00;
`else
                state_reg <= FIN;
                done      <= 1'b1;
`endif
              end else begin
                state_reg <= ADDR;
              end
            end
          end

          ADDR: state_reg <= LOAD;

          LOAD: begin
            shift_reg     <= mem_dat_i;
            byte_idx_reg  <= '0;
            cur_adr_reg   <= cur_adr_reg + 1'b1;
            remaining_reg <= remaining_reg - 1'b1;
            tx_valid      <= 1'b1;
            tx_data       <= mem_dat_i[mem_size-1 -: 8];
            state_reg     <= SEND;
          end

          SEND: begin
            if (hs) begin
              shift_reg    <= shift_next;
              byte_idx_reg <= byte_idx_reg + 1'b1;
`ifdef MEM_READOUT_CSUM_EN
              csum_reg     <= csum_reg ^ tx_data;
`endif
              if (byte_idx_reg == LAST_IDX) begin
                if (remaining_reg != '0) begin
                  state_reg <= ADDR;
                  mem_adr   <= cur_adr_reg;
                  tx_valid  <= 1'b0;
                end else begin
`ifdef MEM_READOUT_CSUM_EN
                  // checksum must fold in the byte being accepted right now
                  state_reg <= TAIL;
                  tx_data   <= csum_reg ^ tx_data;
`else
                  state_reg <= FIN;
                  done      <= 1'b1;
                  tx_valid  <= 1'b0;
`endif
                end
              end else begin
                tx_data <= shift_next[mem_size-1 -: 8];
              end
            end
          end

`ifdef MEM_READOUT_CSUM_EN
          TAIL: begin
            if (hs) begin
              tx_valid  <= 1'b0;
              state_reg <= FIN;
              done      <= 1'b1;
            end
          end
`endif

          FIN: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end

          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            tx_valid  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_readout.sv
// Scoreboard bench for mem_readout: stimulus queues expected bytes, a negedge monitor checks them.
module tb_mem_readout;

  localparam int W     = 11;
  localparam int MS    = 32;
  localparam int DEPTH = 1 << W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  base_adr;
  logic [W:0]    count;
  logic          busy;
  logic          done;
  logic [W-1:0]  mem_adr;
  logic          mem_we;
  logic [MS-1:0] mem_dat_i;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;

  logic [MS-1:0] mem [0:DEPTH-1];
  logic [7:0]    exp_q [$];

  int n_vec = 0;
  int n_err = 0;
  int hs_count = 0;
  int done_seen = 0;
  int exp_done = 0;
  int busy_cycles = 0;
  int ready_mode = 0;
  int phase = 0;
  bit prev_stall = 0;
  bit prev_done = 0;
  logic [7:0] prev_data = 8'h00;

  mem_readout #(.width(W), .mem_size(MS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_adr(base_adr), .count(count), .busy(busy), .done(done),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat_i(mem_dat_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // synchronous-read memory with one cycle of latency
  always @(posedge clk) mem_dat_i <= mem[mem_adr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // reference: words in address order (modulo depth), bytes MSB first, optional XOR tail
  task automatic push_expect(input int base, input int cnt);
    logic [MS-1:0] w;
    logic [7:0]    b;
    logic [7:0]    cs;
    cs = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      w = mem[(base + i) % DEPTH];
      for (int k = MS / 8 - 1; k >= 0; k--) begin
        b = w[8*k +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef MEM_READOUT_CSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready && !abort) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL byte_unexpected: got 0x%02h, required no byte", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_err++;
            $display("FAIL byte_data: got 0x%02h, required 0x%02h", tx_data, e);
          end
        end
        hs_count++;
      end
      if (busy) busy_cycles++;
      if (done) begin
        chk("done_width", {31'd0, prev_done}, 32'd0);
        chk("done_bytes_left", exp_q.size(), 32'd0);
        done_seen++;
        chk("done_expected", {31'd0, done_seen <= exp_done}, 32'd1);
      end
      prev_done  = done;
      prev_stall = tx_valid && !tx_ready && !abort;
      prev_data  = tx_data;
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          tx_ready = (phase == 0);
          phase = (phase + 1) % 3;
        end
      endcase
    end
  end

  task automatic pulse_start(input int base, input int cnt);
    @(posedge clk); #1;
    start = 1'b1; base_adr = W'(base); count = (W+1)'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (done_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_vec++;
    if (done_seen < target) begin
      n_err++;
      $display("FAIL %s_timeout: done count %0d, required %0d", nm, done_seen, target);
    end
  endtask

  task automatic run_xfer(input int base, input int cnt, input bit poke, input string nm);
    int tgt;
    push_expect(base, cnt);
    exp_done++;
    tgt = exp_done;
    busy_cycles = 0;
    pulse_start(base, cnt);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; base_adr = W'(base + 100); count = 1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(tgt, 100 + cnt * 60, nm);
    chk({nm, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    if (cnt > 0) chk({nm, "_last_adr"}, {21'd0, mem_adr}, 32'((base + cnt - 1) % DEPTH));
    $display("xfer %s: base=%0d count=%0d busy_cycles=%0d", nm, base, cnt, busy_cycles);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, d0, n, b, c, extra;
    extra = 0;
`ifdef MEM_READOUT_CSUM_EN
    extra = 1;
`endif
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_adr = '0; count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[5] = 32'h11223344;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_adr", {21'd0, mem_adr}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;

    ready_mode = 0;
    run_xfer(5, 1, 1'b0, "basic");
    chk("basic_busy_cycles", busy_cycles, 32'(7 + extra));

    phase = 0; ready_mode = 2;
    run_xfer(5, 1, 1'b0, "backpressure");

    ready_mode = 1;
    run_xfer(2047, 3, 1'b0, "wrap");

    ready_mode = 0;
    run_xfer(77, 0, 1'b0, "zero");
    chk("zero_busy_cycles", busy_cycles, 32'(1 + extra));

    // abort on the second byte of the second word
    h0 = hs_count; d0 = done_seen;
    b = $urandom_range(0, DEPTH - 1);
    push_expect(b, 4);
    pulse_start(b, 4);
    n = 0;
    while (!(hs_count == h0 + 5 && tx_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("abort_reached", {31'd0, n < 200}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", {31'd0, tx_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sent", hs_count - h0, 32'd5);
    chk("abort_left", exp_q.size(), 32'(11 + extra));
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_seen, d0);
    $display("xfer abort: base=%0d count=4 bytes_sent=%0d", b, hs_count - h0);
    run_xfer($urandom_range(0, DEPTH - 1), 2, 1'b0, "post_abort");

    // start together with abort in IDLE stays idle
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_abort_valid", {31'd0, tx_valid}, 32'd0);
    $display("xfer start+abort in idle: busy=%0d", busy);

    run_xfer($urandom_range(0, DEPTH - 1), 3, 1'b1, "start_while_busy");
    d0 = done_seen;
    repeat (6) @(posedge clk);
    #1;
    chk("poke_no_extra_done", done_seen, d0);
    chk("poke_idle", {31'd0, busy}, 32'd0);

    // reset in the middle of SEND
    ready_mode = 0;
    h0 = hs_count;
    b = $urandom_range(0, DEPTH - 1);
    push_expect(b, 3);
    pulse_start(b, 3);
    n = 0;
    while (!(hs_count >= h0 + 2 && tx_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("reset_reached", {31'd0, n < 200}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    exp_done = done_seen;
    $display("xfer reset mid-send: base=%0d bytes_before_reset=%0d", b, hs_count - h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_xfer(5, 1, 1'b0, "post_reset");

    for (int t = 0; t < 8; t++) begin
      ready_mode = $urandom_range(0, 1);
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, 5);
      run_xfer(b, c, (c >= 3) && ($urandom_range(0, 1) == 1), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
